// File: rtl/warp_icache.sv
// Two-bank direct-mapped instruction cache returning 8 bytes per fetch; a fetch
// may straddle two sequential lines, which always live in opposite banks.
module warp_icache #(
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ren,
  input  logic [63:0] i_raddr,
  input  logic        i_flush,
  output logic        o_valid,
  output logic [63:0] o_rdata,
  output logic        o_mem_req,
  output logic [63:0] o_mem_addr,
  input  logic        i_mem_rvalid,
  input  logic [63:0] i_mem_rdata
);

  localparam int unsigned LINE_BYTES = LINE_BEATS * 8;
  localparam int unsigned LINE_W     = LINE_BEATS * 64;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
  localparam int unsigned SETS       = NUM_LINES / 2;
  localparam int unsigned IDX_W      = $clog2(SETS);
  localparam int unsigned LN_W       = 64 - OFF_W;
  localparam int unsigned TAG_W      = LN_W - 1 - IDX_W;
  localparam int unsigned BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int unsigned SH_W       = OFF_W + 3;

  typedef enum logic [1:0] {IDLE, FILL_A, FILL_B, RESPOND} state_t;

  state_t              state, state_d;
  logic [BEAT_W-1:0]   beat_cnt, beat_d;
  logic                flush_pend;
  logic [63:0]         req_addr;
  logic                need_fb, need_fb_d;
  logic                valid_d, mem_req_d;
  logic [63:0]         rdata_d, mem_addr_d;
  logic                accept, fill_wr, fill_line, flush_clr;

  logic [LINE_W-1:0]   data_even [SETS];
  logic [LINE_W-1:0]   data_odd  [SETS];
  logic [TAG_W-1:0]    tag_even  [SETS];
  logic [TAG_W-1:0]    tag_odd   [SETS];
  logic [SETS-1:0]     vld_even, vld_odd;

  // Lookup of both banks: the request address in IDLE, the latched one afterwards
  logic [63:0]         lk_addr;
  logic [LN_W-1:0]     line_a_num, line_b_num;
  logic [LN_W-2:0]     even_set, odd_set;
  logic [IDX_W-1:0]    e_idx, o_idx;
  logic                a_odd, even_hit, odd_hit, hit_a, hit_b, need_b;
  logic [OFF_W-1:0]    off_even;
  logic [LINE_W-1:0]   line_a_data, line_b_data;
  logic [2*LINE_W-1:0] win;
  logic [SH_W-1:0]     sh;
  logic [63:0]         rdata_c;

  assign lk_addr    = (state == IDLE) ? i_raddr : req_addr;
  assign line_a_num = lk_addr[63:OFF_W];
  assign line_b_num = line_a_num + LN_W'(1);
  assign a_odd      = line_a_num[0];
  assign even_set   = a_odd ? line_b_num[LN_W-1:1] : line_a_num[LN_W-1:1];
  assign odd_set    = a_odd ? line_a_num[LN_W-1:1] : line_b_num[LN_W-1:1];
  assign e_idx      = even_set[IDX_W-1:0];
  assign o_idx      = odd_set[IDX_W-1:0];
  assign even_hit   = vld_even[e_idx] && (tag_even[e_idx] == even_set[LN_W-2:IDX_W]) && !flush_pend;
  assign odd_hit    = vld_odd[o_idx]  && (tag_odd[o_idx]  == odd_set[LN_W-2:IDX_W])  && !flush_pend;
  assign hit_a      = a_odd ? odd_hit  : even_hit;
  assign hit_b      = a_odd ? even_hit : odd_hit;
  assign off_even   = {lk_addr[OFF_W-1:1], 1'b0};
  assign need_b     = off_even > OFF_W'(LINE_BYTES - 8);

  assign line_a_data = a_odd ? data_odd[o_idx]  : data_even[e_idx];
  assign line_b_data = a_odd ? data_even[e_idx] : data_odd[o_idx];
  assign win         = {line_b_data, line_a_data};
  assign sh          = {off_even, 3'b000};
  assign rdata_c     = 64'(win >> sh);

  // Fill target decoded from the held fill address
  logic [LN_W-1:0]  f_num;
  logic             f_odd;
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             last_beat;

  assign f_num     = o_mem_addr[63:OFF_W];
  assign f_odd     = f_num[0];
  assign f_idx     = f_num[1 +: IDX_W];
  assign f_tag     = f_num[LN_W-1 -: TAG_W];
  assign last_beat = (beat_cnt == BEAT_W'(LINE_BEATS - 1));

  logic unused_bits;
  assign unused_bits = ^{lk_addr[0], o_mem_addr[OFF_W-1:0]};

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state;
    beat_d     = beat_cnt;
    need_fb_d  = need_fb;
    valid_d    = 1'b0;
    rdata_d    = o_rdata;
    mem_req_d  = 1'b0;
    mem_addr_d = o_mem_addr;
    accept     = 1'b0;
    fill_wr    = 1'b0;
    fill_line  = 1'b0;
    flush_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        flush_clr = flush_pend;
        if (i_ren) begin
          accept    = 1'b1;
          need_fb_d = need_b && !hit_b;
          if (hit_a && (!need_b || hit_b)) begin
            valid_d = 1'b1;
            rdata_d = rdata_c;
          end else if (!hit_a) begin
            state_d    = FILL_A;
            mem_req_d  = 1'b1;
            mem_addr_d = {line_a_num, OFF_W'(0)};
          end else begin
            state_d    = FILL_B;
            mem_req_d  = 1'b1;
            mem_addr_d = {line_b_num, OFF_W'(0)};
          end
        end
      end
      FILL_A, FILL_B: begin
        if (i_mem_rvalid) begin
          fill_wr = 1'b1;
          if (last_beat) begin
            beat_d    = '0;
            fill_line = 1'b1;
            if (state == FILL_A && need_fb) begin
              state_d    = FILL_B;
              mem_req_d  = 1'b1;
              mem_addr_d = {line_b_num, OFF_W'(0)};
            end else begin
              state_d = RESPOND;
            end
          end else begin
            beat_d = beat_cnt + BEAT_W'(1);
          end
        end
      end
      RESPOND: begin
        valid_d = 1'b1;
        rdata_d = rdata_c;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      req_addr   <= '0;
      need_fb    <= 1'b0;
      o_valid    <= 1'b0;
      o_rdata    <= '0;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      vld_even   <= '0;
      vld_odd    <= '0;
    end else begin
      state      <= state_d;
      beat_cnt   <= beat_d;
      need_fb    <= need_fb_d;
      o_valid    <= valid_d;
      o_rdata    <= rdata_d;
      o_mem_req  <= mem_req_d;
      o_mem_addr <= mem_addr_d;
      flush_pend <= i_flush | (flush_pend & ~flush_clr);
      if (accept) req_addr <= i_raddr;
      if (flush_clr) begin
        vld_even <= '0;
        vld_odd  <= '0;
      end else if (fill_line) begin
        if (f_odd) vld_odd[f_idx]  <= 1'b1;
        else       vld_even[f_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them
  always_ff @(posedge i_clk) begin
    if (fill_wr) begin
      if (f_odd) data_odd[f_idx][{beat_cnt, 6'b0} +: 64]  <= i_mem_rdata;
      else       data_even[f_idx][{beat_cnt, 6'b0} +: 64] <= i_mem_rdata;
    end
    if (fill_line) begin
      if (f_odd) tag_odd[f_idx]  <= f_tag;
      else       tag_even[f_idx] <= f_tag;
    end
  end

endmodule
